tx_sequencer: RTL
=================

# tx_sequencer

Slave-side transmit sequencer for I2C read transfers. Once the controller has acknowledged a read address, it serialises bytes onto SDA, one bit per SCL low phase, and releases SDA for the master's ACK/NACK slot. It samples that slot and either requests the next byte or ends the transfer. It is driven by the same SCL edge-detect and start/stop detectors as the receive path.

## Interface
- BYTE_BITS, 8, data bits per byte before the ACK slot
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- rising_edge_found  in  1  one-cycle pulse on SCL rise
- falling_edge_found  in  1  one-cycle pulse on SCL fall
- start_found  in  1  one-cycle pulse on START or repeated START
- stop_found  in  1  one-cycle pulse on STOP
- sda_in  in  1  synchronised SDA line level, used to sample the master ACK
- tx_start  in  1  pulse from the controller: begin a read transfer; SCL is low at this point
- tx_data  in  BYTE_BITS  byte to transmit; must be valid when it is captured
- sda_out  out  1  SDA drive value; 1 = release (high-Z), 0 = pull low
- busy  out  1  high in every state except IDLE
- byte_sent  out  1  one-cycle pulse when the last data bit's low phase ends
- data_req  out  1  one-cycle pulse asking for the next byte on tx_data
- nack_received  out  1  one-cycle pulse when the master NACKs

## Operation
- States: IDLE, SHIFT, ACK_WAIT, ACK_SAMPLED, DONE.
- IDLE + tx_start: capture tx_data into the shift register, drive its MSB, clear the bit counter, go to SHIFT. tx_start in any other state is ignored.
- SHIFT, on falling_edge_found:
  - Increment the bit counter and shift left, driving the next bit.
  - On the BYTE_BITS-th fall, set sda_out=1, pulse byte_sent, go to ACK_WAIT.
- ACK_WAIT, on rising_edge_found: sample sda_in, go to ACK_SAMPLED.
  - sda_in=0 (ACK): pulse data_req.
  - sda_in=1 (NACK): pulse nack_received.
- ACK_SAMPLED, on falling_edge_found:
  - After ACK: capture tx_data, drive its MSB, clear the counter, go to SHIFT.
  - After NACK: keep sda_out=1, go to DONE.
- DONE: sda_out held at 1; go to IDLE on stop_found or start_found.
- Abort: stop_found or start_found in any non-IDLE state forces IDLE with sda_out=1. Abort has priority over every edge input in the same cycle, and no pulse outputs are generated in that cycle.
- Coincident rising_edge_found and falling_edge_found is illegal: hold state and outputs.
- Bit counter: 4 bits wide, counts falling edges 0..BYTE_BITS, cleared whenever not in SHIFT.

## Timing
- All outputs are registered.
- Reset values: sda_out=1, busy=0, byte_sent=0, data_req=0, nack_received=0, state IDLE, counter 0, shift register 0.
- tx_start in cycle N: MSB appears on sda_out and busy=1 at N+1.
- Edge pulse in cycle N: new sda_out and any pulse output appear at N+1. This lands within the SCL low phase, which is many clk cycles long.
- data_req leads the byte capture by one full SCL high phase. The controller must present tx_data before the next falling_edge_found.
- Reset mid-transfer: immediate release of SDA (sda_out=1); all state is lost.

## Structure
- Shared package i2c_pkg holds:
  - typedef enum logic [2:0] tx_state_t: IDLE, SHIFT, ACK_WAIT, ACK_SAMPLED, DONE
  - localparam BYTE_BITS_DEFAULT = 8
- Sub-module: flex_counter, instantiated with NUM_CNT_BITS=4, rollover_val=BYTE_BITS, count_enable=falling_edge_found in SHIFT. Its rollover_flag marks the end of the byte.
- The shift register and FSM are local to tx_sequencer.

## Test plan
- Single byte, NACK: tx_start with tx_data=0xA5, then 8 SCL pulses.
  - sda_out samples at SCL rises must read 1,0,1,0,0,1,0,1.
  - byte_sent pulses after the 8th fall and sda_out=1.
  - sda_in=1 at the 9th rise gives nack_received=1, state DONE; stop_found returns to IDLE with busy=0.
- Two bytes with ACK: 0x3C, then sda_in=0 at the 9th rise.
  - data_req pulses once.
  - Controller presents 0xC3; the 9th fall loads it and the bits read 1,1,0,0,0,0,1,1.
- Stop mid-byte: stop_found after 3 falls of 0xFF gives IDLE and sda_out=1 next cycle, with no byte_sent.
- Repeated START in ACK_WAIT: start_found gives IDLE, busy=0 and no nack_received, even if rising_edge_found coincides.
- Reset mid-byte: n_rst low during bit 4 gives sda_out=1 and busy=0 asynchronously. A later tx_start with 0x81 transmits cleanly from the MSB.
- tx_start while busy: tx_start during SHIFT of 0x55 leaves the shift register unaffected, and 0x55 completes intact.

Source files
------------

// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Types and constants shared by the I2C slave blocks.
//   tx_state_t        : state encoding of the transmit sequencer
//   BYTE_BITS_DEFAULT : data bits per byte before the ACK/NACK slot
// ----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        ACK_WAIT,
        ACK_SAMPLED,
        DONE
    } tx_state_t;

    localparam int BYTE_BITS_DEFAULT = 8;

endpackage

// File: rtl/flex_counter.sv
// ----------------------------------------------------------------------------
// flex_counter
// Up-counter with synchronous clear and programmable rollover value.
// Counts 0,1,..,rollover_val and wraps to 1 on the enable after rollover_val.
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   clear          : synchronous clear to 0 (wins over count_enable)
//   count_enable   : advance the count this cycle
//   rollover_val   : terminal count
//   count_out      : current count (registered)
//   rollover_flag  : high in the cycle whose enabled increment reaches
//                    rollover_val, so the user can react on the same edge
// ----------------------------------------------------------------------------
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] next_count;

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        next_count = count_out;
        if (clear) begin
            next_count = '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                next_count = NUM_CNT_BITS'(1);
            end else begin
                next_count = count_out + NUM_CNT_BITS'(1);
            end
        end
    end

    // Flag is combinational on purpose: the sequencer must react to the
    // final falling edge in the same cycle to keep its outputs one cycle late.
    assign rollover_flag = !clear && count_enable && (next_count == rollover_val);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else begin
            count_out <= next_count;
        end
    end

endmodule

// File: rtl/tx_sequencer.sv
// ----------------------------------------------------------------------------
// tx_sequencer
// Slave-side transmit sequencer for I2C read transfers. Shifts a byte out
// MSB first (one bit per SCL low phase), releases SDA for the master's
// ACK/NACK slot, samples it on SCL rise, then either loads the next byte or
// waits for STOP / repeated START.
// Ports:
//   clk, n_rst           : clock, asynchronous active-low reset
//   rising_edge_found    : one-cycle pulse on SCL rise
//   falling_edge_found   : one-cycle pulse on SCL fall
//   start_found          : one-cycle pulse on START / repeated START
//   stop_found           : one-cycle pulse on STOP
//   sda_in               : synchronised SDA level (master ACK sampling)
//   tx_start             : begin a read transfer (only honoured in IDLE)
//   tx_data              : byte to transmit
//   sda_out              : SDA drive, 1 = release, 0 = pull low (registered)
//   busy                 : high outside IDLE (registered)
//   byte_sent            : pulse after the last data bit's low phase
//   data_req             : pulse after an ACK, asking for the next tx_data
//   nack_received        : pulse after a NACK
// ----------------------------------------------------------------------------
module tx_sequencer
    import i2c_pkg::*;
#(
    parameter int BYTE_BITS = BYTE_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rising_edge_found,
    input  logic                 falling_edge_found,
    input  logic                 start_found,
    input  logic                 stop_found,
    input  logic                 sda_in,
    input  logic                 tx_start,
    input  logic [BYTE_BITS-1:0] tx_data,
    output logic                 sda_out,
    output logic                 busy,
    output logic                 byte_sent,
    output logic                 data_req,
    output logic                 nack_received
);

    localparam logic [3:0] ROLLOVER = 4'(BYTE_BITS);

    tx_state_t            state, state_n;
    logic [BYTE_BITS-1:0] shreg, shreg_n;
    logic                 acked, acked_n;
    logic                 sda_n, byte_sent_n, data_req_n, nack_n;
    logic                 abort, edge_clash, cnt_en, cnt_clear, byte_done;
    logic [3:0]           bit_count;

    assign abort      = (start_found || stop_found) && (state != IDLE);
    assign edge_clash = rising_edge_found && falling_edge_found;
    assign cnt_en     = (state == SHIFT) && falling_edge_found && !abort && !edge_clash;
    assign cnt_clear  = (state != SHIFT);

    flex_counter #(
        .NUM_CNT_BITS(4)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (ROLLOVER),
        .count_out    (bit_count),
        .rollover_flag(byte_done)
    );

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        acked_n     = acked;
        sda_n       = sda_out;
        byte_sent_n = 1'b0;
        data_req_n  = 1'b0;
        nack_n      = 1'b0;

        if (abort) begin
            // Abort beats any edge in the same cycle and emits no pulses.
            state_n = IDLE;
            sda_n   = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    sda_n = 1'b1;
                    if (tx_start) begin
                        shreg_n = tx_data;
                        sda_n   = tx_data[BYTE_BITS-1];
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (falling_edge_found && !edge_clash) begin
                        // Rotate rather than shift: the outgoing MSB refills
                        // the bottom, which is never driven again this byte.
                        shreg_n = {shreg[BYTE_BITS-2:0], shreg[BYTE_BITS-1]};
                        if (byte_done) begin
                            sda_n       = 1'b1;
                            byte_sent_n = 1'b1;
                            state_n     = ACK_WAIT;
                        end else begin
                            sda_n = shreg[BYTE_BITS-2];
                        end
                    end
                end
                ACK_WAIT: begin
                    if (rising_edge_found && !edge_clash) begin
                        acked_n    = !sda_in;
                        data_req_n = !sda_in;
                        nack_n     = sda_in;
                        state_n    = ACK_SAMPLED;
                    end
                end
                ACK_SAMPLED: begin
                    if (falling_edge_found && !edge_clash) begin
                        if (acked) begin
                            shreg_n = tx_data;
                            sda_n   = tx_data[BYTE_BITS-1];
                            state_n = SHIFT;
                        end else begin
                            sda_n   = 1'b1;
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    sda_n = 1'b1;
                end
                default: begin
                    sda_n   = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end
    end

    // NOTE: the shift register is a handful of flops, not a memory, so it is
    // reset with everything else and SDA is released the instant n_rst drops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            shreg         <= '0;
            acked         <= 1'b0;
            sda_out       <= 1'b1;
            busy          <= 1'b0;
            byte_sent     <= 1'b0;
            data_req      <= 1'b0;
            nack_received <= 1'b0;
        end else begin
            state         <= state_n;
            shreg         <= shreg_n;
            acked         <= acked_n;
            sda_out       <= sda_n;
            busy          <= (state_n != IDLE);
            byte_sent     <= byte_sent_n;
            data_req      <= data_req_n;
            nack_received <= nack_n;
        end
    end

    // The bit counter can never run past the end of a byte.
    a_count_range : assert property (@(posedge clk) disable iff (!n_rst)
        bit_count <= ROLLOVER);

endmodule
